fsub_iter: RTL and testbench

//  Multi-cycle IEEE-754 floating-point subtractor (out = a - b), the inverse-direction companion to
//  the combinational adder. Accepts one operand pair per valid/ready handshake, aligns, subtracts,

---
 rtl/fp_pkg.sv | 46 ++++
 rtl/fp_align_shift.sv | 26 ++
 rtl/fsub_iter.sv | 192 +++++++++++++++++++
 tb/tb_fsub_iter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: format constants, subtractor FSM states and the
// unpacked operand record used by the iterative add/sub datapath.
package fp_pkg;

    localparam int EXP_LEN_SP = 8;
    localparam int MAN_LEN_SP = 23;
    localparam int BIAS_SP    = 127;
    localparam int EXP_MAX_SP = 255;

    localparam int EXP_LEN_DP = 11;
    localparam int MAN_LEN_DP = 52;
    localparam int BIAS_DP    = 1023;
    localparam int EXP_MAX_DP = 2047;

    // Record widths cover the widest format; narrower formats zero-extend into them.
    // The exponent keeps one spare bit so exp+1 never wraps.
    localparam int EXP_W  = EXP_LEN_DP + 1;
    localparam int MANT_W = MAN_LEN_DP + 3;

    function automatic int exp_len(input int n);
        return (n == 64) ? EXP_LEN_DP : EXP_LEN_SP;
    endfunction

    function automatic int man_len(input int n);
        return (n == 64) ? MAN_LEN_DP : MAN_LEN_SP;
    endfunction

    function automatic int exp_max(input int n);
        return (n == 64) ? EXP_MAX_DP : EXP_MAX_SP;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SUB,
        NORM,
        DONE
    } fsub_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_unpacked_t;

endpackage

// File: rtl/fp_align_shift.sv
// Combinational right shifter for mantissa alignment; the first bit shifted out is kept
// as a guard bit and anything past MAX_SHIFT flushes the mantissa to zero.
module fp_align_shift #(
    parameter int W         = 24,
    parameter int SW        = 12,
    parameter int MAX_SHIFT = W + 1
) (
    input  logic [W-1:0]  din,
    input  logic [SW-1:0] shamt,
    output logic [W-1:0]  dout,
    output logic          guard
);

    logic [W:0] ext;

    always_comb begin
        ext = {din, 1'b0} >> shamt;
        if (shamt > SW'(MAX_SHIFT)) begin
            ext = '0;
        end
    end

    assign dout  = ext[W:1];
    assign guard = ext[0];

endmodule

// File: rtl/fsub_iter.sv
// Multi-cycle IEEE-754 subtractor (out = a - b): align, subtract, then normalise one bit
// per cycle; the result is held until the consumer takes it. Truncating, flush-to-zero.
module fsub_iter
    import fp_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         busy
);

    localparam int EL  = exp_len(N);
    localparam int ML  = man_len(N);
    localparam int HID = ML + 1;
    localparam int CRY = ML + 2;
    localparam logic [EXP_W-1:0] EMAX    = EXP_W'(exp_max(N));
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    fsub_state_t       state;
    logic [N-1:0]      op_a;
    logic [N-1:0]      op_b;
    fp_unpacked_t      x;
    logic              y_sign;
    logic [MANT_W-1:0] y_mant;
    fp_unpacked_t      r;

    function automatic fp_unpacked_t unpack(input logic [N-1:0] v);
        fp_unpacked_t u;
        u.sign = v[N-1];
        u.exp  = EXP_W'(v[N-2 -: EL]);
        u.mant = MANT_W'({1'b1, v[ML-1:0], 1'b0});
        return u;
    endfunction

    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic             a_zero;
    logic             b_zero;
    logic             a_spec;
    logic             b_spec;
    logic             is_special;
    logic [N-1:0]     special_out;
    logic [N-1:0]     big_w;
    logic [N-1:0]     sml_w;
    fp_unpacked_t     big_u;
    logic [EXP_W-1:0] shamt;
    logic [ML:0]      sh_mant;
    logic             sh_guard;

    assign exp_a  = EXP_W'(op_a[N-2 -: EL]);
    assign exp_b  = EXP_W'(op_b[N-2 -: EL]);
    assign a_zero = (exp_a == '0);
    assign b_zero = (exp_b == '0);
    assign a_spec = (exp_a == EMAX);
    assign b_spec = (exp_b == EMAX);
    assign is_special = a_zero | b_zero | a_spec | b_spec;

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        special_out = op_b;
        if (a_spec) begin
            special_out = op_a;
        end else if (b_spec) begin
            special_out = op_b;
        end else if (a_zero && b_zero) begin
            special_out = '0;
        end else if (b_zero) begin
            special_out = op_a;
        end
    end

    // Larger magnitude goes first; comparing exponent and fraction as one integer does that.
    always_comb begin
        big_w = op_a;
        sml_w = op_b;
        if (op_a[N-2:0] < op_b[N-2:0]) begin
            big_w = op_b;
            sml_w = op_a;
        end
    end

    assign big_u = unpack(big_w);
    assign shamt = big_u.exp - EXP_W'(sml_w[N-2 -: EL]);

    fp_align_shift #(
        .W         (ML + 1),
        .SW        (EXP_W),
        .MAX_SHIFT (ML + 2)
    ) u_align (
        .din   ({1'b1, sml_w[ML-1:0]}),
        .shamt (shamt),
        .dout  (sh_mant),
        .guard (sh_guard)
    );

    logic             norm_done;
    logic [EXP_W-1:0] exp_inc;
    logic [N-1:0]     norm_out;

    assign exp_inc   = r.exp + EXP_ONE;
    assign norm_done = r.mant[CRY] | r.mant[HID] | (r.mant == '0) | (r.exp == '0);

    always_comb begin
        norm_out = {r.sign, r.exp[EL-1:0], r.mant[ML:1]};
        if (r.mant[CRY]) begin
            if (exp_inc >= EMAX) begin
                norm_out = {r.sign, {EL{1'b1}}, {ML{1'b0}}};
            end else begin
                norm_out = {r.sign, exp_inc[EL-1:0], r.mant[ML+1:2]};
            end
        end else if (r.mant == '0) begin
            norm_out = '0;
        end else if (r.exp == '0) begin
            norm_out = {r.sign, {(N-1){1'b0}}};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            x         <= '0;
            y_sign    <= 1'b0;
            y_mant    <= '0;
            r         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a     <= a;
                        op_b     <= {~b[N-1], b[N-2:0]};
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (is_special) begin
                        out       <= special_out;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        x      <= big_u;
                        y_sign <= sml_w[N-1];
                        y_mant <= MANT_W'({sh_mant, sh_guard});
                        state  <= SUB;
                    end
                end
                SUB: begin
                    r.sign <= x.sign;
                    r.exp  <= x.exp;
                    r.mant <= (x.sign == y_sign) ? x.mant + y_mant : x.mant - y_mant;
                    state  <= NORM;
                end
                NORM: begin
                    if (norm_done) begin
                        out       <= norm_out;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        r.mant <= r.mant << 1;
                        r.exp  <= r.exp - EXP_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsub_iter.sv
// Self-checking bench for fsub_iter (N=32): directed cases plus randomized operands
// compared against an integer-arithmetic reference of the subtraction rules.
module tb_fsub_iter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    int n_cmp;
    int n_err;

    fsub_iter #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: a - b with guard-bit alignment, truncation and flush-to-zero.
    // lat is the number of clock edges from accept to out_valid.
    function automatic logic [31:0] ref_sub(input logic [31:0] x, input logic [31:0] y,
                                            output int lat);
        logic [31:0] nb, big, sml;
        int ea, eb, d, e;
        longint mb, ms, m;
        logic s;
        nb  = {~y[31], y[30:0]};
        ea  = int'(x[30:23]);
        eb  = int'(nb[30:23]);
        lat = 2;
        if (ea == 255) return x;
        if (eb == 255) return nb;
        if (ea == 0 && eb == 0) return 32'h0;
        if (eb == 0) return x;
        if (ea == 0) return nb;
        lat = 4;
        if (x[30:0] >= nb[30:0]) begin
            big = x;
            sml = nb;
        end else begin
            big = nb;
            sml = x;
        end
        mb = longint'({1'b1, big[22:0]}) * 2;
        ms = longint'({1'b1, sml[22:0]}) * 2;
        d  = int'(big[30:23]) - int'(sml[30:23]);
        ms = (d > 25) ? 64'd0 : (ms >> d);
        m  = (big[31] == sml[31]) ? mb + ms : mb - ms;
        e  = int'(big[30:23]);
        s  = big[31];
        if (m >= (64'd1 << 25)) begin
            if (e + 1 >= 255) return {s, 8'hFF, 23'h0};
            return {s, 8'(e + 1), 23'((m >> 2) & 64'h7F_FFFF)};
        end
        if (m == 0) return 32'h0;
        while (m < (64'd1 << 24) && e > 0) begin
            m = m * 2;
            e = e - 1;
            lat++;
        end
        if (e == 0) return {s, 31'h0};
        return {s, 8'(e), 23'((m >> 1) & 64'h7F_FFFF)};
    endfunction

    // One full transaction: accept, wait for the result, hold out_ready low for stall
    // cycles (result must stay put), then hand it over.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_b, input int stall,
                          input string tag, output logic [31:0] res, output int lat);
        @(negedge clk);
        check({tag, "/in_ready_idle"}, 64'(in_ready), 64'd1);
        a        = ta;
        b        = tb_b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, "/hold_out"}, 64'(out), 64'(res));
            check({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "/valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "/in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic directed(input logic [31:0] ta, input logic [31:0] tb_b, input int stall,
                            input logic [31:0] exp_res, input int exp_lat, input string tag);
        logic [31:0] res;
        int lat;
        run_op(ta, tb_b, stall, tag, res, lat);
        check({tag, "/out"}, 64'(res), 64'(exp_res));
        if (exp_lat > 0) check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        logic [31:0] ra, rb, res, exp_res;
        int lat, exp_lat, mode;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/out_valid", 64'(out_valid), 64'd0);
        check("reset/out", 64'(out), 64'd0);
        check("reset/in_ready", 64'(in_ready), 64'd1);
        check("reset/busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        directed(32'h4040_0000, 32'h3F80_0000, 0, 32'h4000_0000, 4,  "sub_3_1");
        directed(32'h3F80_0000, 32'hBF80_0000, 0, 32'h4000_0000, 4,  "carry");
        directed(32'h3F80_0000, 32'h3F7F_FFFF, 0, 32'h3380_0000, 28, "guard_norm");
        directed(32'h3F80_0000, 32'h3F80_0000, 0, 32'h0000_0000, 4,  "cancel");
        directed(32'h0000_0000, 32'h3F80_0000, 0, 32'hBF80_0000, 2,  "a_zero");
        directed(32'h4040_0000, 32'h3F80_0000, 5, 32'h4000_0000, 4,  "stall");
        directed(32'h7F7F_FFFF, 32'hFF7F_FFFF, 0, 32'h7F80_0000, 4,  "overflow");
        directed(32'h8080_0001, 32'h8080_0000, 0, 32'h8000_0000, 5,  "underflow");
        directed(32'h4120_0000, 32'h0000_0000, 0, 32'h4120_0000, 2,  "b_zero");
        directed(32'h7FC0_0001, 32'h3F80_0000, 0, 32'h7FC0_0001, 2,  "a_nan");

        // Reset in the middle of the long normalisation of the guard case.
        @(negedge clk);
        a        = 32'h3F80_0000;
        b        = 32'h3F7F_FFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst/out_valid", 64'(out_valid), 64'd0);
        check("midrst/out", 64'(out), 64'd0);
        check("midrst/in_ready", 64'(in_ready), 64'd1);
        check("midrst/busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("midrst/no_result", 64'(out_valid), 64'd0);
        directed(32'h4040_0000, 32'h3F80_0000, 0, 32'h4000_0000, 4, "after_rst");

        for (int i = 0; i < 250; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            mode = $urandom_range(0, 3);
            case (mode)
                1: rb = ra ^ 32'($urandom_range(0, 255));
                2: rb = {1'($urandom_range(0, 1)),
                         8'(ra[30:23] + 8'($urandom_range(0, 4)) - 8'd2), 23'($urandom)};
                3: begin
                    if ($urandom_range(0, 1) == 1)
                        ra[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
                    else
                        rb[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
                end
                default: ;
            endcase
            exp_res = ref_sub(ra, rb, exp_lat);
            run_op(ra, rb, $urandom_range(0, 2), "rand", res, lat);
            check("rand/out", 64'(res), 64'(exp_res));
            check("rand/latency", 64'(lat), 64'(exp_lat));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
